mips_write_checker: RTL
=======================

// Module: mips_write_checker
// PURPOSE
// - Synthesizable, parametrised checker for the Mips memwrite port; successor to the bench-only single-write check.
// - Holds a table of DEPTH expected (address, data) stores and matches CPU stores against it in order.
// - Writes to a configurable scratch address are ignored.
// - Reports pass / fail / timeout with failure capture.
// - Sits beside the Mips core (simulation top or FPGA self-test), tapping aluresult, writedata and memwrite.
// PARAMETERS
// - ADDR_W       32    width of data_address / expected address
// - DATA_W       32    width of writedata / expected data
// - DEPTH        8     max expected-store entries (>=1)
// - TIMEOUT_CYC  50    RUN cycles allowed before TIMEOUT (>=1)
// - IGNORE_EN    1     1 = stores to IGNORE_ADDR are skipped, 0 = every store is checked
// - IGNORE_ADDR  80    scratch address skipped when IGNORE_EN=1
// PORTS
// - clk         in   1                   rising-edge clock
// - reset       in   1                   synchronous, active-high; clears all state
// - memwrite    in   1                   CPU store strobe, sampled on rising clk
// - data_addr   in   ADDR_W              CPU store address (aluresult)
// - writedata   in   DATA_W              CPU store data
// - exp_we      in   1                   append {exp_addr, exp_data} to table (LOAD only)
// - exp_addr    in   ADDR_W              expected address
// - exp_data    in   DATA_W              expected data
// - start       in   1                   1-cycle pulse: LOAD/terminal -> RUN
// - clear       in   1                   empty table, go to LOAD
// - busy        out  1                   1 in RUN
// - pass        out  1                   sticky; all entries matched
// - fail        out  1                   sticky; mismatching store seen
// - timeout     out  1                   sticky; TIMEOUT_CYC elapsed in RUN
// - load_ovf    out  1                   sticky; exp_we while table full
// - match_cnt   out  clog2(DEPTH+1)      entries matched so far
// - fail_addr   out  ADDR_W              address of first mismatching store
// - fail_data   out  DATA_W              data of first mismatching store
// BEHAVIOUR
// - Reset (sync, high): state=LOAD, table count=0, all outputs 0. Reset mid-RUN aborts; no status survives.
// - States: LOAD, RUN, PASS, FAIL, TIMEOUT. busy=(RUN); pass/fail/timeout each = its state (one-hot, never two set).
// - LOAD:
//   - exp_we writes entry[count], count++.
//   - When count==DEPTH, exp_we is dropped and load_ovf=1.
//   - start -> RUN next cycle with idx=0, timer=0, match_cnt=0. start with count==0 -> PASS next cycle.
//   - memwrite is ignored in LOAD.
// - RUN, each cycle with memwrite=1:
//   - IGNORE_EN && data_addr==IGNORE_ADDR: no effect.
//   - Else if {data_addr, writedata}==entry[idx]: idx++, match_cnt++. If idx was count-1 -> PASS next cycle.
//   - Else -> FAIL next cycle; latch fail_addr/fail_data; match_cnt frozen.
// - RUN timer: increments every cycle. When timer==TIMEOUT_CYC-1 and no PASS/FAIL event that cycle -> TIMEOUT.
// - Same-cycle priority: final match (PASS) > mismatch (FAIL) > timer expiry (TIMEOUT).
// - Equality uses full widths; X/Z are not modelled (synth compare).
// - Terminal states (PASS/FAIL/TIMEOUT) hold until start, clear or reset.
//   - start re-arms RUN with the same table; fail_* and match_cnt are cleared.
//   - clear -> LOAD, count=0, load_ovf=0, all status 0.
//   - clear beats start if both are asserted. clear in RUN aborts to LOAD.
//   - exp_we is ignored outside LOAD.
// - Latency: memwrite sample -> status visible 1 cycle later (registered outputs).
// STRUCTURE
// - Shared package mips_chk_pkg: state encoding localparams (LOAD, RUN, PASS, FAIL, TIMEOUT), status codes.
// - Sub-module chk_exp_table: DEPTH x (ADDR_W+DATA_W) register file.
//   - Write port: count pointer. Combinational read port: idx.
//   - Outputs count and full.
// - Top level: FSM, timer, idx/match_cnt counters, failure capture registers.
// TESTING
// - Defaults. Load {(84,7)}, start; CPU stores (80,x), (80,y), (84,7) -> pass=1 one cycle after the (84,7) store, match_cnt=1, fail=0.
// - Load {(84,7)}, start; store (88,3) -> fail=1, fail_addr=88, fail_data=3, match_cnt=0.
// - IGNORE_EN=0, table {(84,7)}: store (80,5) -> fail=1, fail_addr=80.
// - TIMEOUT_CYC=10, no stores after start -> timeout=1 on cycle 11 after start, busy=0.
//   - Variant: final match on the expiry cycle -> pass=1, timeout=0.
// - DEPTH=2, 3 exp_we -> load_ovf=1, count=2.
//   - Table {(4,1), (8,2)}; stores (4,1), (8,2) -> pass=1, match_cnt=2.
//   - Then start -> busy=1, match_cnt=0.
// - Reset asserted 1 cycle mid-RUN after 1 match -> all outputs 0, state LOAD, table empty; subsequent start -> pass=1 next cycle.

Source files
------------

// File: rtl/mips_chk_pkg.sv
// Shared definitions for the Mips memwrite checker: FSM state encoding.
package mips_chk_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } chk_state_e;

endpackage

// File: rtl/chk_exp_table.sv
// Expected-store register file: appended through a count pointer,
// read combinationally at the checker's current match index.
module chk_exp_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CNT_W-1:0]  idx,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W+DATA_W-1:0] rd;

    assign full = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (we && !full) begin
            count <= count + CNT_W'(1);
        end
    end

    // Entries are never cleared; count alone defines which ones are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && !full && count == CNT_W'(i)) begin
                mem[i] <= {wr_addr, wr_data};
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx == CNT_W'(i)) begin
                rd = mem[i];
            end
        end
    end

    assign {rd_addr, rd_data} = rd;

endmodule

// File: rtl/mips_write_checker.sv
// Checks Mips memwrite stores, in order, against a loaded table of
// expected (address, data) pairs; reports pass / fail / timeout.
module mips_write_checker
    import mips_chk_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 50,
    parameter int IGNORE_EN   = 1,
    parameter int IGNORE_ADDR = 80
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       memwrite,
    input  logic [ADDR_W-1:0]          data_addr,
    input  logic [DATA_W-1:0]          writedata,
    input  logic                       exp_we,
    input  logic [ADDR_W-1:0]          exp_addr,
    input  logic [DATA_W-1:0]          exp_data,
    input  logic                       start,
    input  logic                       clear,
    output logic                       busy,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic                       load_ovf,
    output logic [$clog2(DEPTH+1)-1:0] match_cnt,
    output logic [ADDR_W-1:0]          fail_addr,
    output logic [DATA_W-1:0]          fail_data
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    chk_state_e        state_q, state_d, armed_state;
    logic [CNT_W-1:0]  count, idx;
    logic              full;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [TMR_W-1:0]  timer;
    logic              tbl_we, arm, store, is_match, last, expire;

    chk_exp_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear),
        .we      (tbl_we),
        .wr_addr (exp_addr),
        .wr_data (exp_data),
        .idx     (idx),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .count   (count),
        .full    (full)
    );

    assign store    = memwrite &&
                      !((IGNORE_EN != 0) && (data_addr == ADDR_W'(IGNORE_ADDR)));
    assign is_match = (data_addr == rd_addr) && (writedata == rd_data);
    assign last     = ((idx + CNT_W'(1)) == count);
    assign expire   = (timer == TMR_W'(TIMEOUT_CYC - 1));

    // An empty table has nothing to wait for, so arming goes straight to PASS.
    assign armed_state = (count == '0) ? ST_PASS : ST_RUN;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tbl_we  = 1'b0;
        arm     = 1'b0;
        if (clear) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    tbl_we = exp_we;
                    if (start) begin
                        arm     = 1'b1;
                        state_d = armed_state;
                    end
                end
                ST_RUN: begin
                    if (store && is_match && last) begin
                        state_d = ST_PASS;
                    end else if (store && !is_match) begin
                        state_d = ST_FAIL;
                    end else if (expire) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                default: begin
                    if (start) begin
                        arm     = 1'b1;
                        state_d = armed_state;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx       <= '0;
            timer     <= '0;
            match_cnt <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            load_ovf  <= 1'b0;
        end else begin
            if (tbl_we && full) begin
                load_ovf <= 1'b1;
            end
            if (arm) begin
                idx       <= '0;
                timer     <= '0;
                match_cnt <= '0;
                fail_addr <= '0;
                fail_data <= '0;
            end else if (state_q == ST_RUN) begin
                timer <= timer + TMR_W'(1);
                if (store && is_match) begin
                    idx       <= idx + CNT_W'(1);
                    match_cnt <= match_cnt + CNT_W'(1);
                end
                if (store && !is_match) begin
                    fail_addr <= data_addr;
                    fail_data <= writedata;
                end
            end
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign pass    = (state_q == ST_PASS);
    assign fail    = (state_q == ST_FAIL);
    assign timeout = (state_q == ST_TIMEOUT);

endmodule
